// File: rtl/twi_master_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : twi_master_sequencer
// Description : Single-byte TWI master. One accepted command becomes
//               START, address+R/W, ACK, data (write or read), ACK/NACK, STOP
//               on the open-drain SCL/SDA drives.
// Ports       : iClk, iReset        - clock, asynchronous active-high reset
//               iStart              - command strobe (taken only when idle)
//               iRead, iAddress,
//               iData               - command fields, latched on accept
//               iSda                - SDA pad input
//               oSda, oScl          - pad drives (0 pulls low, 1 releases)
//               oData               - last byte read
//               oBusy, oDone        - in-progress flag, end-of-transaction pulse
//               oAckError           - slave NACK seen in current transaction
// Revision    : 1.0 - initial release
// ============================================================================
module twi_master_sequencer #(
    parameter int CLK_DIV = 250
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iRead,
    input  logic [6:0] iAddress,
    input  logic [7:0] iData,
    input  logic       iSda,
    output logic       oSda,
    output logic       oScl,
    output logic [7:0] oData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAckError
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_AACK  = 4'd3,
        S_WRITE = 4'd4,
        S_WACK  = 4'd5,
        S_READ  = 4'd6,
        S_RNACK = 4'd7,
        S_STOP  = 4'd8
    } state_t;

    localparam logic [15:0] c_quarterLast = 16'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_quarterCnt;
    logic [1:0]  r_phase;
    logic [2:0]  r_bitIdx;
    logic        r_rd;
    logic [6:0]  r_addr;
    logic [7:0]  r_wrData;
    logic [7:0]  r_shift;

    logic        w_accept;
    logic        w_tick;
    logic        w_sample;
    logic        w_bitEnd;
    logic        w_shiftState;
    logic [1:0]  w_phaseNext;
    logic [2:0]  w_bitIdxNext;
    logic        w_sdaNext;
    logic        w_sclNext;
    logic        w_sclData;
    logic [7:0]  w_addrByte;

    assign w_accept     = (r_state == S_IDLE) && iStart;
    assign w_tick       = (r_state != S_IDLE) && (r_quarterCnt == c_quarterLast);
    assign w_sample     = w_tick && (r_phase == 2'd2);
    assign w_bitEnd     = w_tick && (r_phase == 2'd3);
    assign w_shiftState = (r_state == S_ADDR) || (r_state == S_WRITE) || (r_state == S_READ);
    assign w_addrByte   = {r_addr, r_rd};

    // Phase and bit index are computed one step ahead so that the registered
    // pad drives line up exactly with the state/quarter they belong to.
    assign w_phaseNext  = w_accept ? 2'd0 : (w_tick ? r_phase + 2'd1 : r_phase);
    assign w_bitIdxNext = w_accept ? 3'd7 :
                          ((w_bitEnd && w_shiftState) ? r_bitIdx - 3'd1 : r_bitIdx);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (iStart) w_nextState = S_START;
            S_START: if (w_bitEnd) w_nextState = S_ADDR;
            S_ADDR:  if (w_bitEnd && (r_bitIdx == 3'd0)) w_nextState = S_AACK;
            // oAckError was already updated on the q2 sample of this bit.
            S_AACK:  if (w_bitEnd) w_nextState = oAckError ? S_STOP : (r_rd ? S_READ : S_WRITE);
            S_WRITE: if (w_bitEnd && (r_bitIdx == 3'd0)) w_nextState = S_WACK;
            S_WACK:  if (w_bitEnd) w_nextState = S_STOP;
            S_READ:  if (w_bitEnd && (r_bitIdx == 3'd0)) w_nextState = S_RNACK;
            S_RNACK: if (w_bitEnd) w_nextState = S_STOP;
            S_STOP:  if (w_bitEnd) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Data-bit SCL shape: low in q0/q3, high in q1/q2.
    assign w_sclData = w_phaseNext[0] ^ w_phaseNext[1];

    always_comb begin
        w_sdaNext = 1'b1;
        w_sclNext = 1'b1;
        case (w_nextState)
            S_START: begin
                w_sdaNext = ~w_phaseNext[1];
                w_sclNext = (w_phaseNext != 2'd3);
            end
            S_STOP: begin
                w_sdaNext = w_phaseNext[1];
                w_sclNext = (w_phaseNext != 2'd0);
            end
            S_ADDR: begin
                w_sdaNext = w_addrByte[w_bitIdxNext];
                w_sclNext = w_sclData;
            end
            S_WRITE: begin
                w_sdaNext = r_wrData[w_bitIdxNext];
                w_sclNext = w_sclData;
            end
            S_AACK, S_WACK, S_READ, S_RNACK: begin
                w_sdaNext = 1'b1;
                w_sclNext = w_sclData;
            end
            default: begin
                w_sdaNext = 1'b1;
                w_sclNext = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_quarterCnt <= 16'd0;
            r_phase      <= 2'd0;
            r_bitIdx     <= 3'd0;
            r_rd         <= 1'b0;
            r_addr       <= 7'd0;
            r_wrData     <= 8'd0;
            r_shift      <= 8'd0;
            oSda         <= 1'b1;
            oScl         <= 1'b1;
            oData        <= 8'd0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oAckError    <= 1'b0;
        end else begin
            r_phase  <= w_phaseNext;
            r_bitIdx <= w_bitIdxNext;
            oSda     <= w_sdaNext;
            oScl     <= w_sclNext;
            oDone    <= (r_state == S_STOP) && w_bitEnd;

            if (w_accept) begin
                r_quarterCnt <= 16'd0;
                r_rd         <= iRead;
                r_addr       <= iAddress;
                r_wrData     <= iData;
                oBusy        <= 1'b1;
                oAckError    <= 1'b0;
            end else begin
                r_quarterCnt <= (w_tick || (r_state == S_IDLE)) ? 16'd0 : r_quarterCnt + 16'd1;

                if (w_sample && ((r_state == S_AACK) || (r_state == S_WACK)) && iSda) begin
                    oAckError <= 1'b1;
                end
                if (w_sample && (r_state == S_READ)) begin
                    r_shift <= {r_shift[6:0], iSda};
                end
                // The last bit was shifted in on q2, so the register is complete here.
                if (w_bitEnd && (r_state == S_READ) && (r_bitIdx == 3'd0)) begin
                    oData <= r_shift;
                end
                if (w_bitEnd && (r_state == S_STOP)) begin
                    oBusy <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_twi_master_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_twi_master_sequencer
// Description : Self-checking bench. A bit-level reference built from the bus
//               protocol rules predicts every registered output on every cycle
//               of a transaction; a slave model answers on SDA.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twi_master_sequencer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       iReset = 1'b0;
    logic       iStart = 1'b0;
    logic       iRead = 1'b0;
    logic [6:0] iAddress = 7'd0;
    logic [7:0] iData = 8'd0;
    logic       slaveSda = 1'b1;
    logic       busSda;
    logic       oSda;
    logic       oScl;
    logic [7:0] oData;
    logic       oBusy;
    logic       oDone;
    logic       oAckError;

    int         total = 0;
    int         bad = 0;
    logic [7:0] expData = 8'h00;

    // Open-drain wired-AND of master and slave.
    assign busSda = oSda & slaveSda;

    twi_master_sequencer #(.CLK_DIV(D)) dut (
        .iClk      (clk),
        .iReset    (iReset),
        .iStart    (iStart),
        .iRead     (iRead),
        .iAddress  (iAddress),
        .iData     (iData),
        .iSda      (busSda),
        .oSda      (oSda),
        .oScl      (oScl),
        .oData     (oData),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oAckError (oAckError)
    );

    always #5 clk = ~clk;

    // One transaction; m counts cycles after the accept edge and outputs are
    // observed on the falling edge following each rising edge.
    task automatic run_txn(input string tag, input bit rd, input logic [6:0] addr,
                           input logic [7:0] data, input bit nackA, input bit nackD,
                           input logic [7:0] rdByte, input bit injectStart,
                           input int resetAt, input bit holdStart, input bit already);
        int         nBits;
        int         nCyc;
        int         lastM;
        int         quarter;
        int         k;
        int         q;
        bit         bitVal [0:19];
        logic [7:0] addrByte;
        logic       expSda;
        logic       expScl;
        logic       expBusy;
        logic       expDone;
        logic       expAck;
        logic [7:0] expDat;
        logic [12:0] act;
        logic [12:0] exp;
        logic [12:0] rstVec;

        addrByte = {addr, rd};
        nBits    = nackA ? 11 : 20;
        nCyc     = 4 * D * nBits;
        lastM    = holdStart ? nCyc : nCyc + 1;
        rstVec   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 20; i++) bitVal[i] = 1'b1;
        for (int i = 1; i <= 8; i++) bitVal[i] = addrByte[8 - i];
        if (!rd) for (int i = 10; i <= 17; i++) bitVal[i] = data[17 - i];

        if (!already) begin
            @(negedge clk);
            iRead    = rd;
            iAddress = addr;
            iData    = data;
            iStart   = 1'b1;
        end

        for (int m = 0; m <= lastM; m++) begin
            @(negedge clk);
            quarter = m / D;
            k       = quarter / 4;
            q       = quarter % 4;
            if (m >= nCyc) begin
                expSda  = 1'b1;
                expScl  = 1'b1;
                expBusy = 1'b0;
                expDone = (m == nCyc);
            end else begin
                expBusy = 1'b1;
                expDone = 1'b0;
                if (k == 0) begin
                    expSda = (q < 2);
                    expScl = (q != 3);
                end else if (k == nBits - 1) begin
                    expSda = (q >= 2);
                    expScl = (q != 0);
                end else begin
                    expSda = bitVal[k];
                    expScl = (q == 1) || (q == 2);
                end
            end
            expAck = (nackA && (m >= 4 * D * 9 + 3 * D)) ||
                     (!nackA && !rd && nackD && (m >= 4 * D * 18 + 3 * D));
            expDat = (rd && !nackA && (m >= 4 * D * 18)) ? rdByte : expData;
            exp = {expSda, expScl, expBusy, expDone, expAck, expDat};
            act = {oSda, oScl, oBusy, oDone, oAckError, oData};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL %s m=%0d {sda,scl,busy,done,ackErr,data} got %h want %h",
                         tag, m, act, exp);
            end

            if (m == resetAt) begin
                #1 iReset = 1'b1;
                #1;
                total++;
                if ({oSda, oScl, oBusy, oDone, oAckError, oData} !== rstVec) begin
                    bad++;
                    $display("FAIL %s async_reset got %h want %h", tag,
                             {oSda, oScl, oBusy, oDone, oAckError, oData}, rstVec);
                end
                iStart   = 1'b0;
                slaveSda = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    total++;
                    if ({oSda, oScl, oBusy, oDone, oAckError, oData} !== rstVec) begin
                        bad++;
                        $display("FAIL %s held_reset got %h want %h", tag,
                                 {oSda, oScl, oBusy, oDone, oAckError, oData}, rstVec);
                    end
                end
                iReset = 1'b0;
                expData = 8'h00;
                @(negedge clk);
                total++;
                if ({oSda, oScl, oBusy, oDone, oAckError, oData} !== rstVec) begin
                    bad++;
                    $display("FAIL %s after_reset got %h want %h", tag,
                             {oSda, oScl, oBusy, oDone, oAckError, oData}, rstVec);
                end
                return;
            end

            // Slave response for the bit the next edge belongs to.
            slaveSda = 1'b1;
            if (m < nCyc) begin
                if (k == 9) slaveSda = nackA;
                else if (nBits == 20 && rd && k >= 10 && k <= 17) slaveSda = rdByte[17 - k];
                else if (nBits == 20 && !rd && k == 18) slaveSda = nackD;
            end

            if (!holdStart) begin
                iStart   = injectStart && (m == 50);
                // Command inputs must be latched; scrambling them proves it.
                iRead    = 1'($urandom);
                iAddress = 7'($urandom);
                iData    = 8'($urandom);
            end
        end
        if (rd && !nackA) expData = rdByte;
    endtask

    task automatic test_reset();
        #1 iReset = 1'b1;
        #1;
        total++;
        if ({oSda, oScl, oBusy, oDone, oAckError, oData} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_initial got %h want %h",
                     {oSda, oScl, oBusy, oDone, oAckError, oData}, 13'h1800);
        end
        repeat (3) @(negedge clk);
        iReset = 1'b0;
        @(negedge clk);
        total++;
        if ({oSda, oScl, oBusy, oDone, oAckError, oData} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_idle got %h want %h",
                     {oSda, oScl, oBusy, oDone, oAckError, oData}, 13'h1800);
        end
    endtask

    task automatic test_write();
        run_txn("write_50_A5", 1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, -1, 1'b0, 1'b0);
        run_txn("write_data_nack", 1'b0, 7'h2A, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_read();
        run_txn("read_1D_3C", 1'b1, 7'h1D, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_addr_nack();
        run_txn("addr_nack", 1'b0, 7'h11, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, -1, 1'b0, 1'b0);
        run_txn("after_nack", 1'b0, 7'h12, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_txn("ignore_start", 1'b1, 7'h63, 8'h00, 1'b0, 1'b0, 8'hC9, 1'b1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        run_txn("reset_in_write", 1'b0, 7'h5A, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 208, 1'b0, 1'b0);
        run_txn("post_reset", 1'b1, 7'h44, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", 1'b0, 7'h35, 8'h6B, 1'b0, 1'b0, 8'h00, 1'b0, -1, 1'b1, 1'b0);
        run_txn("b2b_second", 1'b0, 7'h35, 8'h6B, 1'b0, 1'b0, 8'h00, 1'b0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_txn("random", 1'($urandom), 7'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                    8'($urandom), 1'($urandom), -1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_ignore_start();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/twi_master_sequencer.md
# twi_master_sequencer

Byte-level sequencer for the TWI master peripheral. It turns one command (7-bit address, R/W, one data byte) into a complete bus transaction on SCL/SDA: START, address, ACK, data, ACK/NACK, STOP. It sits between the TWI register file and the open-drain pads. It reports completion, acknowledge errors and read data back to the register file.

## Interface
- CLK_DIV, 250: system clocks per SCL quarter-period; legal range 2..65535. The default gives 100 kHz SCL at 100 MHz.
- iClk  in  1  system clock, rising-edge.
- iReset  in  1  asynchronous, active-high reset.
- iStart  in  1  command strobe; accepted only in IDLE.
- iRead  in  1  1 = read transaction, 0 = write; latched on accept.
- iAddress  in  7  slave address; latched on accept.
- iData  in  8  write byte; latched on accept.
- iSda  in  1  SDA pad input.
- oSda  out  1  SDA drive: 0 pulls low, 1 releases.
- oScl  out  1  SCL drive: 0 pulls low, 1 releases.
- oData  out  8  last byte read; holds its value until the next read completes.
- oBusy  out  1  transaction in progress.
- oDone  out  1  one-cycle pulse at the end of a transaction.
- oAckError  out  1  slave NACKed; held until the next accepted iStart.

## Operation
- All outputs are registered.
- Reset values: oSda=1, oScl=1, oData=0x00, oBusy=0, oDone=0, oAckError=0. State returns to IDLE and the counters clear.
- Quarter tick:
  - 16-bit counter runs 0..CLK_DIV-1 while busy; a tick fires when the count equals CLK_DIV-1.
  - The counter is cleared on accept.
  - Each bit period is 4 quarters, q0..q3, tracked by a 2-bit phase counter.
  - A 3-bit bit index counts MSB-first, 7 down to 0.
- Data bit timing:
  - q0: SCL=0, drive SDA.
  - q1 and q2: SCL=1.
  - q3: SCL=0.
  - SDA is sampled on the q2 tick.
- States:
  - IDLE: SCL=1, SDA=1. On iStart, latch inputs, set oBusy, clear oAckError, go to START.
  - START: SDA/SCL per quarter = 1/1, 1/1, 0/1, 0/0. Then go to ADDR.
  - ADDR: 8 bits sent as {iAddress[6:0], iRead}. Then go to AACK.
  - AACK: SDA released; sample on q2. A 1 sets oAckError and goes to STOP; a 0 goes to WRITE if write, READ if read.
  - WRITE: 8 bits of latched iData. Then go to WACK.
  - WACK: SDA released; a sampled 1 sets oAckError. Always goes to STOP.
  - READ: SDA released; shift iSda into an 8-bit shift register on each q2. At the end, copy it to oData and go to RNACK.
  - RNACK: SDA=1 (master NACK, single-byte read). Then go to STOP.
  - STOP: SDA/SCL per quarter = 0/0, 0/1, 1/1, 1/1. Then go to IDLE, clear oBusy, pulse oDone.
- Boundary conditions:
  - iStart while busy is ignored, with no queuing.
  - iStart held high re-triggers on the first IDLE cycle after oDone.
  - Clock stretching and arbitration loss are not supported; iSda is only sampled in acknowledge/read bits.
  - Reset mid-transaction releases both lines immediately. No STOP is generated, and oDone is not pulsed.

## Timing
- Accept edge E0: oBusy=1 from E0.
- Every state change happens on the q3 tick edge of its last bit.
- Full write or read is 20 bit periods = 80·CLK_DIV cycles. At edge E0+80·CLK_DIV, oBusy falls and oDone is high for exactly the following cycle.
- Address NACK is 11 bit periods = 44·CLK_DIV cycles.
- oAckError is set on the q2 tick edge of the acknowledge bit and stays valid with oDone.
- oData changes only on the READ→RNACK edge.
- Minimum iStart-to-iStart turnaround is 80·CLK_DIV+1 cycles.

## Test plan
- Reset: hold iReset mid-cycle, asynchronously -> outputs reach reset values immediately, without waiting for an iClk edge.
- Write, CLK_DIV=4, address 0x50, data 0xA5, slave ACKs -> SDA bits 1010000_0, ACK, 10100101, ACK, STOP. oDone 320 cycles after accept, oAckError=0.
- Read, address 0x1D, slave drives 0x3C -> address byte 0x3B on SDA, oData=0x3C, master NACK bit = 1, oDone after 320 cycles.
- Address NACK: slave leaves SDA high in AACK -> STOP follows directly, oDone 176 cycles after accept, oAckError=1. The next iStart clears oAckError.
- iStart pulsed at cycle 50 of an active transaction -> ignored: latched address/data unchanged, single oDone.
- Reset asserted during the WRITE state -> oSda=1, oScl=1, oBusy=0 with no oDone. A fresh iStart then runs a full, correct transaction.
